spe_omem_port: RTL and testbench

- Clocked packet front-end for one SPE (spiking PE); the initiator side of the output-memory protocol.
- Packs each finished neuron result (residual potential + spike) into an SPE_n SEND_DATA packet.
- In timestep 2, fetches the prior-timestep spike for the current neuron: issues a REQ_DATA packet and waits for the response.
- Tracks the current timestep from TIMESTEP_DONE broadcasts. Sits between the SPE core and its router port.

---
 rtl/spe_omem_if.sv | 30 +++
 rtl/spe_omem_port.sv | 148 ++++++++++++++
 tb/tb_spe_omem_port.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spe_omem_if.sv
// Core/router-side bundle of the SPE output-memory port: result, prior-spike request, tx and rx channels.
// Every channel transfers on a rising clk edge where its valid and ready are both high; a raised valid holds its payload until then.
interface spe_omem_if #(
  parameter int SUM_WIDTH = 13
);
  logic                 res_valid;
  logic                 res_ready;
  logic [SUM_WIDTH-1:0] res_potential;
  logic                 res_spike;
  logic                 req_valid;
  logic                 req_ready;
  logic                 prev_valid;
  logic                 prev_spike;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [32:0]          tx_packet;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [32:0]          rx_packet;

  modport master (
    output res_valid, res_potential, res_spike, req_valid, tx_ready, rx_valid, rx_packet,
    input  res_ready, req_ready, prev_valid, prev_spike, tx_valid, tx_packet, rx_ready
  );

  modport slave (
    input  res_valid, res_potential, res_spike, req_valid, tx_ready, rx_valid, rx_packet,
    output res_ready, req_ready, prev_valid, prev_spike, tx_valid, tx_packet, rx_ready
  );
endinterface

// File: rtl/spe_omem_port.sv
// SPE output-memory initiator: sends result packets, fetches prior-timestep spikes, tracks timestep.
// Optional macro SPE_RESP_TIMEOUT_EN adds a WAIT_RESP timeout of TIMEOUT_CYC cycles.
module spe_omem_port #(
  parameter int SPE_ID      = 0,
  parameter int PE_ADDR     = 0,
  parameter int OMEM_ADDR   = 11,
  parameter int SUM_WIDTH   = 13,
  parameter int NUM_NEURONS = 89,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  spe_omem_if.slave  bus,
  output logic [1:0] ts,
  output logic       ts_done,
  output logic [6:0] neuron_cnt,
  output logic       err,
  output logic [1:0] state_dbg
);

  localparam logic [3:0] OMEM       = 4'(OMEM_ADDR);
  localparam logic [3:0] PE         = 4'(PE_ADDR);
  localparam logic [3:0] SEND_OP    = 4'(2 * SPE_ID);
  localparam logic [3:0] REQ_OP     = 4'(2 * SPE_ID + 1);
  localparam logic [3:0] TS_DONE_OP = 4'hF;
  localparam logic [6:0] NUM_N      = 7'(NUM_NEURONS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_RES  = 2'd1,
    SEND_REQ  = 2'd2,
    WAIT_RESP = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   run;
  logic   res_acc, req_acc, tx_acc, rx_acc;
  logic   is_tsd, is_resp, is_bad, send_done, timeout;

  assign res_acc   = bus.res_valid & bus.res_ready;
  assign req_acc   = bus.req_valid & bus.req_ready;
  assign tx_acc    = bus.tx_valid & bus.tx_ready;
  assign rx_acc    = bus.rx_valid & bus.rx_ready;
  assign send_done = tx_acc && (state == SEND_RES);

  assign is_tsd  = rx_acc && (bus.rx_packet[28:25] == TS_DONE_OP);
  assign is_resp = rx_acc && !is_tsd && (state == WAIT_RESP) && (bus.rx_packet[32:29] == PE);
  assign is_bad  = rx_acc && !is_tsd && !is_resp;

`ifdef SPE_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  tmo_cnt <= '0;
    else if (state != WAIT_RESP) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign timeout = (state == WAIT_RESP) && !is_resp && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // Without the timeout feature WAIT_RESP never gives up; TIMEOUT_CYC is inert.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (res_acc)      state_nx = SEND_RES;
        else if (req_acc) state_nx = SEND_REQ;
      end
      SEND_RES:  if (tx_acc) state_nx = IDLE;
      SEND_REQ:  if (tx_acc) state_nx = WAIT_RESP;
      WAIT_RESP: if (is_resp || timeout) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // req_ready drops while res_valid is high so the result always wins a tie.
  always_comb begin
    bus.res_ready = 1'b0;
    bus.req_ready = 1'b0;
    bus.tx_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.res_ready = run;
        bus.req_ready = run && (ts == 2'd2) && !bus.res_valid;
      end
      SEND_RES, SEND_REQ: bus.tx_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.rx_ready = run;
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run            <= 1'b0;
      ts             <= 2'd1;
      ts_done        <= 1'b0;
      neuron_cnt     <= 7'd0;
      err            <= 1'b0;
      bus.tx_packet  <= '0;
      bus.prev_valid <= 1'b0;
      bus.prev_spike <= 1'b0;
    end else begin
      run            <= 1'b1;
      ts_done        <= 1'b0;
      bus.prev_valid <= 1'b0;

      if (res_acc)
        bus.tx_packet <= {OMEM, SEND_OP, {(24 - SUM_WIDTH){1'b0}}, bus.res_potential, bus.res_spike};
      else if (req_acc)
        bus.tx_packet <= {OMEM, REQ_OP, 20'd0, PE, 1'b0};

      if (res_acc && (neuron_cnt == NUM_N)) err <= 1'b1;

      // A send completing on the TIMESTEP_DONE edge counts toward the new timestep.
      if (is_tsd) begin
        ts         <= (ts == 2'd1) ? 2'd2 : 2'd1;
        ts_done    <= 1'b1;
        neuron_cnt <= send_done ? 7'd1 : 7'd0;
        if (neuron_cnt != NUM_N) err <= 1'b1;
      end else if (send_done && (neuron_cnt != NUM_N)) begin
        neuron_cnt <= neuron_cnt + 7'd1;
      end

      if (is_resp) begin
        bus.prev_valid <= 1'b1;
        bus.prev_spike <= bus.rx_packet[0];
      end else if (timeout) begin
        bus.prev_valid <= 1'b1;
        bus.prev_spike <= 1'b0;
        err            <= 1'b1;
      end

      if (is_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spe_omem_port.sv
// Directed-plus-random bench for spe_omem_port with a timestep/count/error reference model
// and an expected-packet queue for the tx channel.
module tb_spe_omem_port;
  localparam int SPE_ID    = 2;
  localparam int PE_ADDR   = 2;
  localparam int OMEM_ADDR = 11;
  localparam int NUM_N     = 89;
  localparam int TMO       = 8;
  localparam logic [3:0] SEND_OP = 4'd4;
  localparam logic [3:0] REQ_OP  = 4'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ts;
  logic       ts_done;
  logic [6:0] neuron_cnt;
  logic       err;
  logic [1:0] state_dbg;

  spe_omem_if #(.SUM_WIDTH(13)) bus ();

  spe_omem_port #(
    .SPE_ID(SPE_ID), .PE_ADDR(PE_ADDR), .OMEM_ADDR(OMEM_ADDR),
    .SUM_WIDTH(13), .NUM_NEURONS(NUM_N), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .ts(ts), .ts_done(ts_done),
    .neuron_cnt(neuron_cnt), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  int          m_cnt;
  int          m_ts;
  bit          m_err;
  bit          m_wait;
  bit          stall;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("ts", 33'(ts), 33'(m_ts));
    chk("neuron_cnt", 33'(neuron_cnt), 33'(m_cnt));
    chk("err", 33'(err), 33'(m_err));
  endtask

  // tx sink: random backpressure, checks every transferred packet against the queue
  always @(negedge clk) begin
    logic [32:0] p;
    bus.tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    #1;
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      chk("tx_pending", 33'(exp_q.size() != 0), 33'd1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        chk("tx_packet", bus.tx_packet, p);
        if (p[28:25] == SEND_OP && m_cnt < NUM_N) m_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_tx_valid_now", 33'(bus.tx_valid), 33'd0);
    bus.res_valid = 1'b0; bus.req_valid = 1'b0; bus.rx_valid = 1'b0;
    bus.rx_packet = '0; bus.res_potential = '0; bus.res_spike = 1'b0;
    m_cnt = 0; m_ts = 1; m_err = 1'b0; m_wait = 1'b0; stall = 1'b0;
    @(negedge clk); #1;
    chk_model();
    chk("rst_tx_packet", bus.tx_packet, 33'd0);
    chk("rst_res_ready", 33'(bus.res_ready), 33'd0);
    chk("rst_rx_ready", 33'(bus.rx_ready), 33'd0);
    chk("rst_prev_valid", 33'(bus.prev_valid), 33'd0);
    chk("rst_prev_spike", 33'(bus.prev_spike), 33'd0);
    chk("rst_ts_done", 33'(ts_done), 33'd0);
    chk("rst_state", 33'(state_dbg), 33'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic res_send(input logic [12:0] pot, input logic sp);
    int n = 0;
    @(negedge clk);
    bus.res_valid = 1'b1; bus.res_potential = pot; bus.res_spike = sp;
    #2;
    while (!bus.res_ready && n < 200) begin @(negedge clk); #2; n++; end
    chk("res_accept", 33'(bus.res_ready), 33'd1);
    if (bus.res_ready) begin
      if (m_cnt == NUM_N) m_err = 1'b1;
      exp_q.push_back({4'(OMEM_ADDR), SEND_OP, 24'(pot), sp});
    end
    @(negedge clk);
    bus.res_valid = 1'b0;
  endtask

  task automatic req_send();
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    #2;
    while (!bus.req_ready && n < 200) begin @(negedge clk); #2; n++; end
    chk("req_accept", 33'(bus.req_ready), 33'd1);
    if (bus.req_ready) begin
      exp_q.push_back({4'(OMEM_ADDR), REQ_OP, 24'(PE_ADDR), 1'b0});
      m_wait = 1'b1;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // returns at the first negedge after the accepting edge
  task automatic rx_send(input logic [32:0] p);
    int n = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_packet = p;
    #2;
    while (!bus.rx_ready && n < 50) begin @(negedge clk); #2; n++; end
    chk("rx_accept", 33'(bus.rx_ready), 33'd1);
    chk("prev_valid_before", 33'(bus.prev_valid), 33'd0);
    if (p[28:25] == 4'hF) begin
      if (m_cnt != NUM_N) m_err = 1'b1;
      m_ts  = (m_ts == 1) ? 2 : 1;
      m_cnt = 0;
    end else if (m_wait && p[32:29] == 4'(PE_ADDR)) begin
      m_wait = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk); #2;
    while (!(exp_q.size() == 0 && !bus.tx_valid) && n < 300) begin @(negedge clk); #2; n++; end
    chk("drain", 33'(exp_q.size() == 0 && !bus.tx_valid), 33'd1);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) res_send(13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
  endtask

  task automatic ts_flip();
    rx_send({4'd0, 4'hF, 25'd0});
    chk("ts_done_pulse", 33'(ts_done), 33'd1);
    chk("ts_toggle", 33'(ts), 33'(m_ts));
    @(negedge clk);
    chk("ts_done_clear", 33'(ts_done), 33'd0);
  endtask

  task automatic resp_check(input logic sp);
    rx_send({4'(PE_ADDR), 4'd0, 24'd0, sp});
    chk("prev_valid", 33'(bus.prev_valid), 33'd1);
    chk("prev_spike", 33'(bus.prev_spike), 33'(sp));
    @(negedge clk);
    chk("prev_valid_pulse", 33'(bus.prev_valid), 33'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic sp;
    bus.res_valid = 1'b0; bus.req_valid = 1'b0; bus.rx_valid = 1'b0;
    bus.rx_packet = '0; bus.res_potential = '0; bus.res_spike = 1'b0; bus.tx_ready = 1'b0;
    stall = 1'b0;

    do_reset();

    // first result: potential 0x1A3, spike 1 -> data 0x347
    res_send(13'h1A3, 1'b1);
    chk("res_to_tx_latency", 33'(bus.tx_valid), 33'd1);
    wait_idle();
    chk_model();

    // full timestep then TIMESTEP_DONE: no error
    fill(NUM_N - m_cnt);
    wait_idle();
    chk_model();
    ts_flip();
    chk_model();

    // prior-spike fetch in ts 2
    req_send();
    wait_idle();
    resp_check(1'b1);
    chk_model();

    // result and request together: result goes first
    @(negedge clk);
    bus.res_valid = 1'b1; bus.req_valid = 1'b1;
    bus.res_potential = 13'($urandom_range(0, 8191)); bus.res_spike = 1'b0;
    #2;
    chk("tie_req_ready", 33'(bus.req_ready), 33'd0);
    chk("tie_res_ready", 33'(bus.res_ready), 33'd1);
    exp_q.push_back({4'(OMEM_ADDR), SEND_OP, 24'(bus.res_potential), 1'b0});
    @(negedge clk);
    bus.res_valid = 1'b0;
    bus.req_valid = 1'b0;
    req_send();
    wait_idle();
    sp = 1'($urandom_range(0, 1));
    resp_check(sp);
    chk_model();

    // only 88 results this timestep -> err
    fill(NUM_N - 1 - m_cnt);
    wait_idle();
    ts_flip();
    chk_model();

    // stall with TIMESTEP_DONE in the middle
    stall = 1'b1;
    res_send(13'h0F0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("stall_valid", 33'(bus.tx_valid), 33'd1);
      chk("stall_packet", bus.tx_packet, {4'(OMEM_ADDR), SEND_OP, 24'h0F0, 1'b1});
    end
    ts_flip();
    stall = 1'b0;
    wait_idle();
    chk_model();

    // reset during a pending packet
    stall = 1'b1;
    res_send(13'h055, 1'b0);
    do_reset();

    // response in IDLE is unexpected
    rx_send({4'(PE_ADDR), 4'd0, 25'd1});
    chk("stray_prev_valid", 33'(bus.prev_valid), 33'd0);
    chk_model();

    // request in ts 1 is never accepted
    do_reset();
    @(negedge clk);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("ts1_req_ready", 33'(bus.req_ready), 33'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("ts1_no_tx", 33'(bus.tx_valid), 33'd0);

    // saturation: 90th result is sent but flagged
    fill(NUM_N);
    wait_idle();
    chk_model();
    res_send(13'h1FF, 1'b1);
    wait_idle();
    chk_model();

    // dest mismatch while waiting, then proper response
    do_reset();
    fill(NUM_N);
    wait_idle();
    ts_flip();
    req_send();
    wait_idle();
    rx_send({4'd3, 4'd0, 25'd1});
    chk("bad_dest_prev_valid", 33'(bus.prev_valid), 33'd0);
    chk_model();
    resp_check(1'b0);
    chk_model();

`ifdef SPE_RESP_TIMEOUT_EN
    begin
      int n = 0;
      do_reset();
      fill(NUM_N);
      wait_idle();
      ts_flip();
      req_send();
      wait_idle();
      while (!bus.prev_valid && n < 4 * TMO) begin @(negedge clk); n++; end
      chk("tmo_prev_valid", 33'(bus.prev_valid), 33'd1);
      chk("tmo_prev_spike", 33'(bus.prev_spike), 33'd0);
      chk("tmo_err", 33'(err), 33'd1);
      do_reset();
      fill(NUM_N);
      wait_idle();
      ts_flip();
      req_send();
      wait_idle();
      repeat (3) @(negedge clk);
      do_reset();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
